// File: rtl/ls_sequencer.sv
// Moore load/store control sequencer: fetch (T0-T2), address calc (T3-T5), memory access (T6-T7).
// Define LS_MEM_WAIT_EN to stall memory states until MemReady; otherwise each takes one cycle.
module ls_sequencer #(
    parameter int             DATA_W = 32,
    parameter int             OPC_W  = 5,
    parameter logic [OPC_W-1:0] OPC_LD  = 5'b00000,
    parameter logic [OPC_W-1:0] OPC_LDI = 5'b00001,
    parameter logic [OPC_W-1:0] OPC_ST  = 5'b00010
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic [DATA_W-1:0] IR,
    input  logic              MemReady,
    output logic              PCout,
    output logic              PCin,
    output logic              IncPC,
    output logic              MARin,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              Zin,
    output logic              ZLOout,
    output logic              Cout,
    output logic              BAout,
    output logic              Gra,
    output logic              Grb,
    output logic              Rin,
    output logic              Rout,
    output logic              Read,
    output logic              Write,
    output logic              Busy,
    output logic              Done,
    output logic              Illegal,
    output logic [3:0]        Step
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8
    } state_t;

    state_t           state, state_nxt;
    logic [OPC_W-1:0] opc_q;
    logic [OPC_W-1:0] opc_ir;
    logic             ir_ok;
    logic             is_ld, is_ldi, is_st;
    logic             mem_go;

    assign opc_ir = IR[DATA_W-1 -: OPC_W];
    assign ir_ok  = (opc_ir == OPC_LD) || (opc_ir == OPC_LDI) || (opc_ir == OPC_ST);
    assign is_ld  = (opc_q == OPC_LD);
    assign is_ldi = (opc_q == OPC_LDI);
    assign is_st  = (opc_q == OPC_ST);

`ifdef LS_MEM_WAIT_EN
    assign mem_go = MemReady;
`else
    assign mem_go = 1'b1;
`endif

    // Operand bits of IR belong to the datapath; MemReady is only consumed in the wait build.
    logic unused_in;
    assign unused_in = ^{IR[DATA_W-OPC_W-1:0], MemReady};

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= IDLE;
            opc_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == T3)
                opc_q <= opc_ir;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Run) state_nxt = T0;
            T0:      state_nxt = T1;
            T1:      if (mem_go) state_nxt = T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = ir_ok ? T4 : IDLE;
            T4:      state_nxt = T5;
            T5:      state_nxt = is_ldi ? IDLE : T6;
            T6:      if (!is_ld || mem_go) state_nxt = T7;
            T7:      if (!is_st || mem_go) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // IR is itself a register loaded in T2, so the T3 Illegal decode stays a Moore output.
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        ZLOout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Grb     = 1'b1;
                BAout   = 1'b1;
                Yin     = 1'b1;
                Illegal = !ir_ok;
            end
            T4: begin
                Cout = 1'b1;
                Zin  = 1'b1;
            end
            T5: begin
                ZLOout = 1'b1;
                if (is_ldi) begin
                    Gra  = 1'b1;
                    Rin  = 1'b1;
                    Done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            T6: begin
                if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_st) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                    Done   = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                    Done  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign Busy = (state != IDLE);
    assign Step = 4'(state);

endmodule

// File: doc/ls_sequencer.md
LS_SEQUENCER -- requirements
Module: ls_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning IR width.
REQ-002 SHALL have parameter OPC_W, default 5, meaning opcode field width, taken from IR[DATA_W-1 -: OPC_W].
REQ-003 SHALL have parameter OPC_LD, default 5'b00000, meaning load opcode.
REQ-004 SHALL have parameter OPC_LDI, default 5'b00001, meaning load-immediate opcode.
REQ-005 SHALL have parameter OPC_ST, default 5'b00010, meaning store opcode.
REQ-006 SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port Reset_n, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port Run, input, 1 bit, start-fetch request sampled in IDLE only.
REQ-009 SHALL have port IR, input, DATA_W bits, instruction register contents, valid from T3 onward.
REQ-010 SHALL have port MemReady, input, 1 bit, memory completion handshake.
REQ-011 SHALL have outputs PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout, Cout, BAout, Gra, Grb, Rin, Rout, Read, Write, each 1 bit, datapath control strobes.
REQ-012 SHALL have outputs Busy, Done and Illegal, each 1 bit, status.
REQ-013 SHALL have output Step, 4 bits, current step index (0 in IDLE, n+1 in Tn).

Function
REQ-014 SHALL be a Moore FSM; all outputs are decoded from the registered state only.
REQ-015 SHALL use states IDLE, T0..T7, with every strobe low in IDLE.
REQ-016 SHALL move IDLE->T0 on the edge where Run=1; Run is ignored outside IDLE.
REQ-017 SHALL drive in T0: PCout, MARin, IncPC, Zin.
REQ-018 SHALL drive in T1: ZLOout, PCin, Read, MDRin.
REQ-019 SHALL drive in T2: MDRout, IRin.
REQ-020 SHALL drive in T3: Grb, BAout, Yin; an opcode other than LD/LDI/ST in T3 pulses Illegal for one cycle and returns to IDLE next edge.
REQ-021 SHALL drive in T4: Cout, Zin.
REQ-022 SHALL drive in T5 for LDI: ZLOout, Gra, Rin, Done, then go to IDLE; for LD/ST: ZLOout, MARin.
REQ-023 SHALL drive in T6 for LD: Read, MDRin; for ST: Gra, Rout, MDRin (Read low).
REQ-024 SHALL drive in T7 for LD: MDRout, Gra, Rin, Done; for ST: Write, Done; then go to IDLE.
REQ-025 SHALL latch the opcode at T3 and use the latched value through T7.
REQ-026 SHALL hold Busy=1 in every state except IDLE.
REQ-027 SHALL treat T1, T6 (LD only) and T7 (ST only) as memory states, advancing per REQ-034/035.
REQ-028 SHALL, with no memory waits, complete LDI in 6 cycles and LD/ST in 8 cycles after leaving IDLE.
REQ-029 SHALL allow Run=1 in the cycle Done is high to start the next fetch on the following edge (back-to-back via IDLE costs one cycle).

Reset
REQ-030 SHALL, when Reset_n=0 at a rising edge, enter IDLE, clear the latched opcode, and drive all strobes, Busy, Done, Illegal low and Step=0 from the next cycle.
REQ-031 SHALL abandon any in-progress instruction on reset with no Done or Illegal pulse.
REQ-032 SHALL give reset priority over Run and MemReady.

Configuration
REQ-033 SHALL recognise macro LS_MEM_WAIT_EN.
REQ-034 SHALL, with LS_MEM_WAIT_EN defined, hold a memory state and its strobes until an edge with MemReady=1, then advance.
REQ-035 SHALL, without LS_MEM_WAIT_EN, spend exactly one cycle in each memory state and ignore MemReady.

Verification
REQ-036 SHALL cover: reset, Run=1, IR=0x08800075 (LDI R1,0x75), no waits -> T0..T5 one cycle each, Done+Gra+Rin in cycle 6, Busy low cycle 7.
REQ-037 SHALL cover: IR=0x00080045 (LD), MemReady low 3 cycles in T1 and T6 with LS_MEM_WAIT_EN -> Read/MDRin held 4 cycles each, Done after 14 cycles total.
REQ-038 SHALL cover: IR=0x10800020 (ST) -> T6 Rout+Gra+MDRin, T7 Write+Done, Read never high in T6/T7.
REQ-039 SHALL cover: IR opcode 5'b11111 -> Illegal high only in T3, IDLE next cycle, no Done.
REQ-040 SHALL cover: Reset_n=0 during T4 of LD -> all outputs 0 and Step=0 next cycle; new Run then starts cleanly at T0.
REQ-041 SHALL cover: Run held high through LDI -> second T0 begins one cycle after Done (IDLE visited once).
